// File: rtl/wb_burst_expander.sv
// wb_burst_expander: turns one upstream Wishbone request carrying a 1/4/8-beat
// burst hint into a sequence of single accesses on a non-burst slave.
// Each downstream beat is acknowledged upstream with a one-cycle u_ack.
// Optional feature macro: WB_BURST_TIMEOUT_EN adds a 255-cycle slave watchdog
// that reports a stalled beat as u_err.
module wb_burst_expander #(
   parameter int WB_ADDR_W = 24,
   parameter int RW        = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   // upstream (from arbiter)
   input  logic                 u_cyc,
   input  logic                 u_stb,
   input  logic                 u_we,
   input  logic [WB_ADDR_W-1:0] u_adr,
   input  logic [RW-1:0]        u_dat_w,
   input  logic [1:0]           u_sel,
   input  logic                 u_8_burst,
   input  logic                 u_4_burst,
   output logic                 u_ack,
   output logic                 u_err,
   output logic [RW-1:0]        u_dat_r,
   // downstream (single-access slave)
   output logic                 d_cyc,
   output logic                 d_stb,
   output logic                 d_we,
   output logic [WB_ADDR_W-1:0] d_adr,
   output logic [RW-1:0]        d_dat_w,
   output logic [1:0]           d_sel,
   input  logic                 d_ack,
   input  logic                 d_err,
   input  logic [RW-1:0]        d_dat_r
);

   typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [3:0]             len_q, len_d;
   logic [WB_ADDR_W-1:0]   base_q, base_d;
   logic                   we_q, we_d;
   logic [1:0]             sel_q, sel_d;
   logic                   u_ack_q, u_ack_d;
   logic                   u_err_q, u_err_d;
   logic [RW-1:0]          u_dat_r_q, u_dat_r_d;
`ifdef WB_BURST_TIMEOUT_EN
   logic [7:0]             wdog_q, wdog_d;
`endif

   // Next-state logic and downstream strobes; upstream responses are registered.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      base_d    = base_q;
      we_d      = we_q;
      sel_d     = sel_q;
      u_ack_d   = 1'b0;
      u_err_d   = 1'b0;
      u_dat_r_d = u_dat_r_q;
      d_cyc     = 1'b0;
      d_stb     = 1'b0;
`ifdef WB_BURST_TIMEOUT_EN
      wdog_d    = wdog_q;
`endif
      case (state_q)
         IDLE: begin
            if (u_cyc && u_stb) begin
               base_d  = u_adr;
               we_d    = u_we;
               sel_d   = u_sel;
               len_d   = u_8_burst ? 4'd8 : (u_4_burst ? 4'd4 : 4'd1);
               cnt_d   = 4'd0;
               state_d = BEAT;
`ifdef WB_BURST_TIMEOUT_EN
               wdog_d  = 8'd0;
`endif
            end
         end
         BEAT: begin
            // A master abort drops the bus immediately and swallows any ack.
            if (!u_cyc) begin
               state_d = IDLE;
            end else begin
               d_cyc = 1'b1;
               d_stb = 1'b1;
               if (d_err) begin
                  u_err_d = 1'b1;
                  state_d = IDLE;
               end else if (d_ack) begin
                  u_ack_d   = 1'b1;
                  u_dat_r_d = d_dat_r;
                  cnt_d     = cnt_q + 4'd1;
                  state_d   = RESP;
               end
`ifdef WB_BURST_TIMEOUT_EN
               else if (wdog_q == 8'd254) begin
                  // 255th silent cycle: give up on the slave.
                  u_err_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  wdog_d = wdog_q + 8'd1;
               end
`endif
            end
         end
         RESP: begin
            if (!u_cyc) begin
               state_d = IDLE;
            end else begin
               d_cyc = 1'b1;
               if (cnt_q < len_q) begin
                  state_d = BEAT;
`ifdef WB_BURST_TIMEOUT_EN
                  wdog_d  = 8'd0;
`endif
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and response registers with asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         len_q     <= 4'd0;
         base_q    <= '0;
         we_q      <= 1'b0;
         sel_q     <= 2'b00;
         u_ack_q   <= 1'b0;
         u_err_q   <= 1'b0;
         u_dat_r_q <= '0;
`ifdef WB_BURST_TIMEOUT_EN
         wdog_q    <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         base_q    <= base_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         u_ack_q   <= u_ack_d;
         u_err_q   <= u_err_d;
         u_dat_r_q <= u_dat_r_d;
`ifdef WB_BURST_TIMEOUT_EN
         wdog_q    <= wdog_d;
`endif
      end
   end

   assign u_ack   = u_ack_q;
   assign u_err   = u_err_q;
   assign u_dat_r = u_dat_r_q;
   // Beat address wraps naturally at the address width.
   assign d_adr   = base_q + WB_ADDR_W'(cnt_q);
   assign d_we    = we_q;
   assign d_sel   = sel_q;
   assign d_dat_w = u_dat_w;

endmodule

// File: tb/tb_wb_burst_expander.sv
// Self-checking bench for wb_burst_expander: the bench plays master and slave,
// predicting addresses, responses and ack counts from the burst rules.
module tb_wb_burst_expander;

   localparam int AW = 24;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          u_cyc, u_stb, u_we, u_8_burst, u_4_burst;
   logic [AW-1:0] u_adr;
   logic [DW-1:0] u_dat_w;
   logic [1:0]    u_sel;
   logic          u_ack, u_err;
   logic [DW-1:0] u_dat_r;
   logic          d_cyc, d_stb, d_we;
   logic [AW-1:0] d_adr;
   logic [DW-1:0] d_dat_w;
   logic [1:0]    d_sel;
   logic          d_ack, d_err;
   logic [DW-1:0] d_dat_r;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            ack_cnt = 0;
   logic [DW-1:0] exp_dat_r;

   wb_burst_expander #(.WB_ADDR_W(AW), .RW(DW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .u_cyc(u_cyc), .u_stb(u_stb), .u_we(u_we), .u_adr(u_adr),
      .u_dat_w(u_dat_w), .u_sel(u_sel), .u_8_burst(u_8_burst), .u_4_burst(u_4_burst),
      .u_ack(u_ack), .u_err(u_err), .u_dat_r(u_dat_r),
      .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr),
      .d_dat_w(d_dat_w), .d_sel(d_sel),
      .d_ack(d_ack), .d_err(d_err), .d_dat_r(d_dat_r)
   );

   always #5 clk = ~clk;

   // Upstream ack pulses observed on the bus, away from the active edge.
   always @(negedge clk) if (u_ack) ack_cnt <= ack_cnt + 1;

   // Master + slave for one request.
   // mode: 0 normal, 1 slave error at at_beat, 2 master abort at at_beat,
   //       3 reset at at_beat, 4 slave stall at at_beat.
   task automatic run_burst(input logic [AW-1:0] base, input logic f8, input logic f4,
                            input logic we, input logic [1:0] sel, input int mode,
                            input int at_beat, input int dly, input int rdata);
      int            len, k, acks0, exp_acks;
      logic [AW-1:0] exp_adr;
      logic [DW-1:0] data;
      logic          done;
      len      = f8 ? 8 : (f4 ? 4 : 1);
      acks0    = ack_cnt;
      exp_acks = 0;
      done     = 1'b0;
      @(negedge clk);
      u_cyc = 1'b1; u_stb = 1'b1; u_adr = base; u_we = we; u_sel = sel;
      u_8_burst = f8; u_4_burst = f4;
      @(negedge clk);
      // Request attributes must be ignored from here on.
      u_stb = 1'b0; u_adr = AW'($urandom); u_we = 1'($urandom); u_sel = 2'($urandom);
      u_8_burst = 1'($urandom); u_4_burst = 1'($urandom);
      for (int i = 0; i < len && !done; i++) begin
         exp_adr = base + AW'(i);
         u_dat_w = DW'($urandom);
         #1;
         n_tests++;
         if ({d_cyc, d_stb, d_adr, d_we, d_sel, d_dat_w, u_ack, u_err} !==
             {2'b11, exp_adr, we, sel, u_dat_w, 2'b00}) begin
            n_fail++;
            $display("FAIL beat%0d_request: got %h want %h", i,
                     {d_cyc, d_stb, d_adr, d_we, d_sel, d_dat_w, u_ack, u_err},
                     {2'b11, exp_adr, we, sel, u_dat_w, 2'b00});
         end
         if (mode == 2 && i == at_beat) begin
            u_cyc = 1'b0; d_ack = 1'($urandom); d_dat_r = DW'($urandom);
            #1;
            n_tests++;
            if ({d_cyc, d_stb} !== 2'b00) begin
               n_fail++;
               $display("FAIL abort_drop: got cyc/stb %b want 00", {d_cyc, d_stb});
            end
            @(negedge clk);
            d_ack = 1'b0;
            done  = 1'b1;
         end else if (mode == 3 && i == at_beat) begin
            rst_n = 1'b0;
            #1;
            exp_dat_r = '0;
            n_tests++;
            if ({d_cyc, d_stb, u_ack, u_err, u_dat_r} !== {4'b0000, exp_dat_r}) begin
               n_fail++;
               $display("FAIL reset_mid_burst: got %h want %h",
                        {d_cyc, d_stb, u_ack, u_err, u_dat_r}, {4'b0000, exp_dat_r});
            end
            @(negedge clk);
            rst_n = 1'b1;
            done  = 1'b1;
         end else begin
            if (mode == 4 && i == at_beat) begin
`ifdef WB_BURST_TIMEOUT_EN
               repeat (254) @(negedge clk);
               #1;
               n_tests++;
               if ({u_err, d_stb} !== 2'b01) begin
                  n_fail++;
                  $display("FAIL timeout_early: got err/stb %b want 01", {u_err, d_stb});
               end
               @(negedge clk);
               #1;
               n_tests++;
               if ({u_err, u_ack, d_cyc, d_stb} !== 4'b1000) begin
                  n_fail++;
                  $display("FAIL timeout_err: got %b want 1000", {u_err, u_ack, d_cyc, d_stb});
               end
               @(negedge clk);
               done = 1'b1;
`else
               repeat (300) @(negedge clk);
               #1;
               n_tests++;
               if ({u_err, u_ack, d_cyc, d_stb} !== 4'b0011) begin
                  n_fail++;
                  $display("FAIL stall_wait: got %b want 0011", {u_err, u_ack, d_cyc, d_stb});
               end
`endif
            end else begin
               k = (dly < 0) ? $urandom_range(0, 3) : dly;
               repeat (k) @(negedge clk);
            end
            if (!done) begin
               data = (rdata < 0) ? DW'($urandom) : DW'(rdata);
               d_dat_r = data;
               if (mode == 1 && i == at_beat) begin
                  d_err = 1'b1; d_ack = 1'($urandom);
               end else begin
                  d_ack = 1'b1;
               end
               @(negedge clk);
               d_ack = 1'b0; d_err = 1'b0;
               #1;
               if (mode == 1 && i == at_beat) begin
                  done = 1'b1;
                  n_tests++;
                  if ({u_err, u_ack, d_cyc, d_stb, u_dat_r} !== {4'b1000, exp_dat_r}) begin
                     n_fail++;
                     $display("FAIL slave_err: got %h want %h",
                              {u_err, u_ack, d_cyc, d_stb, u_dat_r}, {4'b1000, exp_dat_r});
                  end
               end else begin
                  exp_dat_r = data;
                  exp_acks++;
                  n_tests++;
                  if ({u_ack, u_err, u_dat_r, d_cyc, d_stb} !== {2'b10, data, 2'b10}) begin
                     n_fail++;
                     $display("FAIL beat%0d_resp: got %h want %h", i,
                              {u_ack, u_err, u_dat_r, d_cyc, d_stb}, {2'b10, data, 2'b10});
                  end
               end
               @(negedge clk);
            end
         end
      end
      // Bus must stay quiet after the burst, with read data held.
      for (int j = 0; j < 3; j++) begin
         #1;
         n_tests++;
         if ({d_cyc, d_stb, u_ack, u_err, u_dat_r} !== {4'b0000, exp_dat_r}) begin
            n_fail++;
            $display("FAIL idle_after_%0d: got %h want %h", j,
                     {d_cyc, d_stb, u_ack, u_err, u_dat_r}, {4'b0000, exp_dat_r});
         end
         @(negedge clk);
      end
      n_tests++;
      if (ack_cnt - acks0 !== exp_acks) begin
         n_fail++;
         $display("FAIL ack_count: got %0d want %0d", ack_cnt - acks0, exp_acks);
      end
      u_cyc = 1'b0; u_stb = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      u_cyc = 1'b0; u_stb = 1'b0; u_we = 1'b0; u_adr = '0; u_dat_w = '0; u_sel = 2'b00;
      u_8_burst = 1'b0; u_4_burst = 1'b0; d_ack = 1'b0; d_err = 1'b0; d_dat_r = '0;
      exp_dat_r = '0;
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if ({u_ack, u_err, u_dat_r, d_cyc, d_stb, d_adr} !== {2'b00, 16'h0, 2'b00, 24'h0}) begin
         n_fail++;
         $display("FAIL reset_state: got %h want 0", {u_ack, u_err, u_dat_r, d_cyc, d_stb, d_adr});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      run_burst(24'h000100, 1'b0, 1'b0, 1'b0, 2'b11, 0, -1, 2, 16'hBEEF);
   endtask

   task automatic test_burst8_write();
      run_burst(24'h000010, 1'b1, 1'b0, 1'b1, 2'b11, 0, -1, -1, -1);
   endtask

   task automatic test_wrap();
      run_burst({AW{1'b1}}, 1'b1, 1'b1, 1'b0, 2'b01, 0, -1, -1, -1);
   endtask

   task automatic test_slave_error();
      run_burst(AW'($urandom), 1'b0, 1'b1, 1'b0, 2'b11, 1, 2, -1, -1);
   endtask

   task automatic test_master_abort();
      run_burst(AW'($urandom), 1'b1, 1'b0, 1'b1, 2'b10, 2, 1, -1, -1);
   endtask

   task automatic test_reset_mid_burst();
      run_burst(AW'($urandom), 1'b1, 1'b0, 1'b0, 2'b11, 3, 1, -1, -1);
   endtask

   task automatic test_stall();
      run_burst(AW'($urandom), 1'b0, 1'b1, 1'b0, 2'b11, 4, 1, -1, -1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++)
         run_burst(AW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   2'($urandom), 0, -1, -1, -1);
   endtask

   // Request held through the end of a burst: no acceptance on the return edge.
   task automatic test_back_to_back();
      logic [AW-1:0] a1, a2;
      logic [DW-1:0] x1, x2;
      a1 = AW'($urandom); a2 = AW'($urandom); x1 = DW'($urandom); x2 = DW'($urandom);
      @(negedge clk);
      u_cyc = 1'b1; u_stb = 1'b1; u_adr = a1; u_we = 1'b0; u_sel = 2'b11;
      u_8_burst = 1'b0; u_4_burst = 1'b0;
      @(negedge clk);
      u_adr = a2;
      #1;
      n_tests++;
      if ({d_stb, d_adr} !== {1'b1, a1}) begin
         n_fail++;
         $display("FAIL b2b_first: got %h want %h", {d_stb, d_adr}, {1'b1, a1});
      end
      d_ack = 1'b1; d_dat_r = x1;
      @(negedge clk);
      d_ack = 1'b0;
      #1;
      n_tests++;
      if ({u_ack, u_dat_r, d_stb} !== {1'b1, x1, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_resp1: got %h want %h", {u_ack, u_dat_r, d_stb}, {1'b1, x1, 1'b0});
      end
      @(negedge clk);
      #1;
      n_tests++;
      if ({d_cyc, d_stb, u_ack} !== 3'b000) begin
         n_fail++;
         $display("FAIL b2b_gap: got %b want 000", {d_cyc, d_stb, u_ack});
      end
      @(negedge clk);
      u_stb = 1'b0;
      #1;
      n_tests++;
      if ({d_stb, d_adr} !== {1'b1, a2}) begin
         n_fail++;
         $display("FAIL b2b_second: got %h want %h", {d_stb, d_adr}, {1'b1, a2});
      end
      d_ack = 1'b1; d_dat_r = x2;
      @(negedge clk);
      d_ack = 1'b0;
      #1;
      exp_dat_r = x2;
      n_tests++;
      if ({u_ack, u_dat_r} !== {1'b1, x2}) begin
         n_fail++;
         $display("FAIL b2b_resp2: got %h want %h", {u_ack, u_dat_r}, {1'b1, x2});
      end
      @(negedge clk);
      u_cyc = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_burst8_write();
      test_wrap();
      test_slave_error();
      test_master_abort();
      test_reset_mid_burst();
      test_stall();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1, "time budget exceeded");
   end

endmodule
